// File: rtl/cpu_run_controller.sv
// cpu_run_controller: sequences CPU reset, checks every channel starts, and times the run until all halt.
module cpu_run_controller #(
   parameter int NUM_CPUS       = 1,
   parameter int RESET_CYCLES   = 1,
   parameter int TIMEOUT_CYCLES = 10000,
   localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1),
   localparam int RC_W          = $clog2(RESET_CYCLES + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [NUM_CPUS-1:0] running,
   output logic                cpu_rst,
   output logic                busy,
   output logic                done,
   output logic                timeout,
   output logic [NUM_CPUS-1:0] start_fail,
   output logic [NUM_CPUS-1:0] finished,
   output logic [CNT_W-1:0]    cycle_count
);
   typedef enum logic [2:0] {S_IDLE, S_RESET, S_CHECK, S_RUN, S_DONE} state_t;
   state_t              state_q, state_d;
   logic [RC_W-1:0]     rcnt_q, rcnt_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_CPUS-1:0] sf_q, sf_d, fin_q, fin_d, fin_now;
   logic                cpu_rst_q, cpu_rst_d, busy_q, busy_d, done_q, done_d, to_q, to_d, complete;
   assign fin_now  = fin_q | (~sf_q & ~running);
   assign complete = &(fin_now | sf_q);
   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      cnt_d     = cnt_q;
      sf_d      = sf_q;
      fin_d     = fin_q;
      cpu_rst_d = cpu_rst_q;
      to_d      = to_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) begin
            state_d   = S_RESET;
            rcnt_d    = RC_W'(RESET_CYCLES - 1);
            cpu_rst_d = 1'b1;
            cnt_d     = '0;
            sf_d      = '0;
            fin_d     = '0;
            to_d      = 1'b0;
         end
         S_RESET: if (rcnt_q == '0) begin
            state_d   = S_CHECK;
            cpu_rst_d = 1'b0;
         end else rcnt_d = rcnt_q - 1'b1;
         S_CHECK: begin
            sf_d    = ~running;
            state_d = &(~running) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            fin_d = fin_now;
            cnt_d = cnt_q + 1'b1;
            // completion on the final cycle takes priority over the timeout limit
            if (complete) state_d = S_DONE;
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_DONE;
               to_d    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_RESET) || (state_d == S_CHECK) || (state_d == S_RUN);
      done_d = state_d == S_DONE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rcnt_q    <= '0;
         cnt_q     <= '0;
         sf_q      <= '0;
         fin_q     <= '0;
         cpu_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         to_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         cnt_q     <= cnt_d;
         sf_q      <= sf_d;
         fin_q     <= fin_d;
         cpu_rst_q <= cpu_rst_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         to_q      <= to_d;
      end
   end
   assign cpu_rst     = cpu_rst_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout     = to_q;
   assign start_fail  = sf_q;
   assign finished    = fin_q;
   assign cycle_count = cnt_q;
endmodule
